// File: rtl/fpu_f2i_ctrl_if.sv
// fpu_f2i_ctrl_if: request, converter and response signals of the float-to-int sequencer
// slave modport is the controller side, master modport is the requester/converter/consumer side.
interface fpu_f2i_ctrl_if #(parameter int std = 31, parameter int TAG_W = 4);
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [std:0]     req0_float, req1_float;
  logic [2:0]       req0_rm, req1_rm, frm;
  logic             req0_signed, req1_signed;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [std:0]     cv_float;
  logic [2:0]       cv_rm;
  logic             cv_opcode_FI, cv_signed, cv_unsigned;
  logic [31:0]      cv_int;
  logic             cv_invalid, cv_inexact;
  logic             rsp_valid, rsp_ready, rsp_src, rsp_nv, rsp_nx;
  logic [31:0]      rsp_int;
  logic [TAG_W-1:0] rsp_tag;
  logic             fflags_nv, fflags_nx, fflags_clr;
  modport slave (
    input  req0_valid, req1_valid, req0_float, req1_float, req0_rm, req1_rm,
           req0_signed, req1_signed, req0_tag, req1_tag, frm,
           cv_int, cv_invalid, cv_inexact, rsp_ready, fflags_clr,
    output req0_ready, req1_ready, cv_float, cv_rm, cv_opcode_FI, cv_signed, cv_unsigned,
           rsp_valid, rsp_int, rsp_src, rsp_tag, rsp_nv, rsp_nx, fflags_nv, fflags_nx
  );
  modport master (
    output req0_valid, req1_valid, req0_float, req1_float, req0_rm, req1_rm,
           req0_signed, req1_signed, req0_tag, req1_tag, frm,
           cv_int, cv_invalid, cv_inexact, rsp_ready, fflags_clr,
    input  req0_ready, req1_ready, cv_float, cv_rm, cv_opcode_FI, cv_signed, cv_unsigned,
           rsp_valid, rsp_int, rsp_src, rsp_tag, rsp_nv, rsp_nx, fflags_nv, fflags_nx
  );
endinterface

// File: rtl/fpu_f2i_ctrl.sv
// fpu_f2i_ctrl: round-robin sequencer sharing one float-to-int converter between two issue ports
// Ports: clk, rst_l (async active-low), bus (fpu_f2i_ctrl_if.slave: req0/req1 issue,
// cv_* converter drive/return, rsp_* result handshake, fflags_* sticky CSR flags).
// Define FPU_F2I_CTRL_FFLAGS_EN to build the sticky flag registers; otherwise fflags_* are 0.
module fpu_f2i_ctrl #(parameter int std = 31, parameter int TAG_W = 4) (
  input logic           clk,
  input logic           rst_l,
  fpu_f2i_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t           state;
  logic             ptr, sel1, open, acc, conv;
  logic [2:0]       sel_rm, op_rm;
  logic [std:0]     op_float;
  logic             op_signed, op_src, res_src, res_nv, res_nx;
  logic [TAG_W-1:0] op_tag, res_tag;
  logic [31:0]      res_int;
  // ptr set means port 1 has priority on a tie
  assign sel1 = bus.req1_valid & (~bus.req0_valid | ptr);
  assign open = rst_l & ((state == IDLE) | ((state == HOLD) & bus.rsp_ready));
  assign bus.req0_ready = open & bus.req0_valid & ~sel1;
  assign bus.req1_ready = open & sel1;
  assign acc = bus.req0_ready | bus.req1_ready;
  assign sel_rm = sel1 ? bus.req1_rm : bus.req0_rm;
  assign conv = state == CONV;
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_float  <= '0;
      op_rm     <= 3'b000;
      op_signed <= 1'b0;
      op_src    <= 1'b0;
      op_tag    <= '0;
      res_int   <= 32'h0;
      res_nv    <= 1'b0;
      res_nx    <= 1'b0;
      res_src   <= 1'b0;
      res_tag   <= '0;
    end else begin
      if (acc) begin
        ptr       <= ~sel1;
        op_float  <= sel1 ? bus.req1_float : bus.req0_float;
        op_rm     <= sel_rm == 3'b111 ? bus.frm : sel_rm;
        op_signed <= sel1 ? bus.req1_signed : bus.req0_signed;
        op_src    <= sel1;
        op_tag    <= sel1 ? bus.req1_tag : bus.req0_tag;
      end
      if (conv) begin
        res_int <= bus.cv_int;
        res_nv  <= bus.cv_invalid;
        res_nx  <= bus.cv_inexact;
        res_src <= op_src;
        res_tag <= op_tag;
      end
      state <= acc ? CONV : conv ? HOLD : ((state == HOLD) & ~bus.rsp_ready) ? HOLD : IDLE;
    end
  // converter inputs are forced to zero outside CONV to isolate the datapath
  assign bus.cv_opcode_FI = conv;
  assign bus.cv_float     = conv ? op_float : '0;
  assign bus.cv_rm        = conv ? op_rm : 3'b000;
  assign bus.cv_signed    = conv & op_signed;
  assign bus.cv_unsigned  = conv & ~op_signed;
  assign bus.rsp_valid    = state == HOLD;
  assign bus.rsp_int      = res_int;
  assign bus.rsp_nv       = res_nv;
  assign bus.rsp_nx       = res_nx;
  assign bus.rsp_src      = res_src;
  assign bus.rsp_tag      = res_tag;
`ifdef FPU_F2I_CTRL_FFLAGS_EN
  logic ff_nv, ff_nx, hs;
  assign hs = (state == HOLD) & bus.rsp_ready;
  // clear applies before the new result's flags are merged, so they survive a same-cycle clear
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      ff_nv <= 1'b0;
      ff_nx <= 1'b0;
    end else begin
      ff_nv <= (ff_nv & ~bus.fflags_clr) | (hs & res_nv);
      ff_nx <= (ff_nx & ~bus.fflags_clr) | (hs & res_nx);
    end
  assign bus.fflags_nv = ff_nv;
  assign bus.fflags_nx = ff_nx;
`else
  logic unused_clr;
  assign unused_clr    = bus.fflags_clr;
  assign bus.fflags_nv = 1'b0;
  assign bus.fflags_nx = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_f2i_ctrl.sv
// tb_fpu_f2i_ctrl: directed checks of arbitration, sequencing, backpressure, flags and reset
module tb_fpu_f2i_ctrl;
`ifdef FPU_F2I_CTRL_FFLAGS_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fpu_f2i_ctrl_if #(.std(31), .TAG_W(4)) bus ();
  fpu_f2i_ctrl #(.std(31), .TAG_W(4)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));
  logic [39:0] rsp;
  logic [37:0] cv;
  logic [1:0]  rdy, ff;
  assign rsp = {bus.rsp_valid, bus.rsp_int, bus.rsp_nv, bus.rsp_nx, bus.rsp_src, bus.rsp_tag};
  assign cv  = {bus.cv_opcode_FI, bus.cv_float, bus.cv_rm, bus.cv_signed, bus.cv_unsigned};
  assign rdy = {bus.req1_ready, bus.req0_ready};
  assign ff  = {bus.fflags_nv, bus.fflags_nx};
  // hand-tabulated converter results for the operands used below
  always_comb begin
    bus.cv_int = 32'hDEADBEEF;
    bus.cv_invalid = 1'b0;
    bus.cv_inexact = 1'b0;
    case (bus.cv_float)
      32'h3FC00000: begin
        bus.cv_int = (bus.cv_rm == 3'b000 || bus.cv_rm == 3'b011 || bus.cv_rm == 3'b100) ? 32'd2 : 32'd1;
        bus.cv_inexact = 1'b1;
      end
      32'hBFC00000: begin
        bus.cv_int = (bus.cv_rm == 3'b001 || bus.cv_rm == 3'b011) ? 32'hFFFFFFFF : 32'hFFFFFFFE;
        bus.cv_inexact = 1'b1;
      end
      32'h7F800000: begin
        bus.cv_int = bus.cv_signed ? 32'h7FFFFFFF : 32'hFFFFFFFF;
        bus.cv_invalid = 1'b1;
      end
      32'hBF800000: begin
        bus.cv_int = bus.cv_signed ? 32'hFFFFFFFF : 32'h0;
        bus.cv_invalid = ~bus.cv_signed;
      end
      32'h40200000: begin
        bus.cv_int = (bus.cv_rm == 3'b011 || bus.cv_rm == 3'b100) ? 32'd3 : 32'd2;
        bus.cv_inexact = 1'b1;
      end
      default: ;
    endcase
  end
  task automatic drive(input bit p, input logic [31:0] f, input logic [2:0] rm, input bit s, input logic [3:0] tag);
    if (p) begin
      bus.req1_valid = 1'b1; bus.req1_float = f; bus.req1_rm = rm; bus.req1_signed = s; bus.req1_tag = tag;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_float = f; bus.req0_rm = rm; bus.req0_signed = s; bus.req0_tag = tag;
    end
  endtask
  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk) #1;
    bus.rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_float = 32'h0; bus.req1_float = 32'h0; bus.req0_rm = 3'b000; bus.req1_rm = 3'b000;
    bus.req0_signed = 1'b0; bus.req1_signed = 1'b0; bus.req0_tag = 4'h0; bus.req1_tag = 4'h0;
    bus.frm = 3'b000; bus.rsp_ready = 1'b0; bus.fflags_clr = 1'b0;
    #2;
    total++; if (rsp !== 40'h0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", rsp); end
    total++; if (cv !== 38'h0) begin bad++; $display("FAIL reset_cv got=%h exp=0", cv); end
    total++; if (rdy !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", rdy); end
    total++; if (ff !== 2'b00) begin bad++; $display("FAIL reset_fflags got=%b exp=00", ff); end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_l = 1'b1;
    @(posedge clk) #1;
  endtask
  task automatic test_rne();
    logic [39:0] e;
    drive(1'b0, 32'h3FC00000, 3'b000, 1'b1, 4'd3);
    #1;
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL rne_ready got=%b exp=01", rdy); end
    @(posedge clk) #1;
    bus.req0_valid = 1'b0;
    total++; if (cv !== {1'b1, 32'h3FC00000, 3'b000, 1'b1, 1'b0}) begin bad++; $display("FAIL rne_cv got=%h", cv); end
    total++; if (rsp !== 40'h0) begin bad++; $display("FAIL rne_early_rsp got=%h exp=0", rsp); end
    @(posedge clk) #1;
    e = {1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 4'd3};
    total++; if (rsp !== e) begin bad++; $display("FAIL rne_rsp got=%h exp=%h", rsp, e); end
    total++; if (cv !== 38'h0) begin bad++; $display("FAIL rne_cv_isolated got=%h exp=0", cv); end
    handshake();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rne_valid_drop got=%b exp=0", bus.rsp_valid); end
    total++; if (ff !== {1'b0, FF}) begin bad++; $display("FAIL rne_fflags got=%b exp=%b", ff, {1'b0, FF}); end
  endtask
  task automatic test_invalid();
    logic [39:0] e;
    drive(1'b0, 32'h7F800000, 3'b001, 1'b0, 4'd7);
    #1;
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL inv_ready got=%b exp=01", rdy); end
    @(posedge clk) #1;
    bus.req0_valid = 1'b0;
    total++; if (cv !== {1'b1, 32'h7F800000, 3'b001, 1'b0, 1'b1}) begin bad++; $display("FAIL inv_cv got=%h", cv); end
    @(posedge clk) #1;
    e = {1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'd7};
    total++; if (rsp !== e) begin bad++; $display("FAIL inv_rsp got=%h exp=%h", rsp, e); end
    handshake();
    total++; if (ff !== {FF, FF}) begin bad++; $display("FAIL inv_fflags got=%b exp=%b", ff, {FF, FF}); end
    bus.fflags_clr = 1'b1;
    @(posedge clk) #1;
    bus.fflags_clr = 1'b0;
    total++; if (ff !== 2'b00) begin bad++; $display("FAIL clr_fflags got=%b exp=00", ff); end
  endtask
  task automatic test_dynamic();
    logic [39:0] e;
    bus.frm = 3'b001;
    drive(1'b1, 32'hBFC00000, 3'b111, 1'b1, 4'd5);
    #1;
    total++; if (rdy !== 2'b10) begin bad++; $display("FAIL dyn_ready got=%b exp=10", rdy); end
    @(posedge clk) #1;
    bus.req1_valid = 1'b0;
    bus.frm = 3'b000;
    total++; if (cv !== {1'b1, 32'hBFC00000, 3'b001, 1'b1, 1'b0}) begin bad++; $display("FAIL dyn_cv got=%h", cv); end
    @(posedge clk) #1;
    e = {1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 4'd5};
    total++; if (rsp !== e) begin bad++; $display("FAIL dyn_rsp got=%h exp=%h", rsp, e); end
    handshake();
    total++; if (ff !== {1'b0, FF}) begin bad++; $display("FAIL dyn_fflags got=%b exp=%b", ff, {1'b0, FF}); end
  endtask
  task automatic test_back_to_back();
    logic [39:0] e;
    drive(1'b0, 32'hBF800000, 3'b000, 1'b0, 4'd1);
    drive(1'b1, 32'h40200000, 3'b000, 1'b1, 4'd2);
    #1;
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL b2b_arb got=%b exp=01", rdy); end
    @(posedge clk) #1;
    bus.req0_valid = 1'b0;
    total++; if (rdy !== 2'b00) begin bad++; $display("FAIL b2b_conv_ready got=%b exp=00", rdy); end
    @(posedge clk) #1;
    e = {1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 4'd1};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(posedge clk) #1;
      total++; if ({rsp, rdy} !== {e, 2'b00}) begin bad++; $display("FAIL b2b_stall%0d got=%h exp=%h", i, {rsp, rdy}, {e, 2'b00}); end
    end
    bus.rsp_ready = 1'b1;
    bus.fflags_clr = 1'b1;
    #1;
    total++; if (rdy !== 2'b10) begin bad++; $display("FAIL b2b_same_cycle got=%b exp=10", rdy); end
    @(posedge clk) #1;
    bus.rsp_ready = 1'b0; bus.fflags_clr = 1'b0; bus.req1_valid = 1'b0;
    total++; if (cv !== {1'b1, 32'h40200000, 3'b000, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_cv got=%h", cv); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", bus.rsp_valid); end
    total++; if (ff !== {FF, 1'b0}) begin bad++; $display("FAIL b2b_clr_merge got=%b exp=%b", ff, {FF, 1'b0}); end
    @(posedge clk) #1;
    e = {1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 4'd2};
    total++; if (rsp !== e) begin bad++; $display("FAIL b2b_rsp2 got=%h exp=%h", rsp, e); end
    handshake();
    total++; if (ff !== {FF, FF}) begin bad++; $display("FAIL b2b_fflags got=%b exp=%b", ff, {FF, FF}); end
  endtask
  task automatic test_reset_mid();
    drive(1'b0, 32'h3FC00000, 3'b010, 1'b1, 4'd9);
    @(posedge clk) #1;
    bus.req0_valid = 1'b0;
    total++; if (bus.cv_opcode_FI !== 1'b1) begin bad++; $display("FAIL mid_conv got=%b exp=1", bus.cv_opcode_FI); end
    rst_l = 1'b0;
    #1;
    total++; if (rsp !== 40'h0) begin bad++; $display("FAIL mid_rsp got=%h exp=0", rsp); end
    total++; if ({cv, rdy, ff} !== 42'h0) begin bad++; $display("FAIL mid_outs got=%h exp=0", {cv, rdy, ff}); end
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      total++; if ({rsp, cv} !== 78'h0) begin bad++; $display("FAIL mid_stale%0d got=%h exp=0", i, {rsp, cv}); end
    end
    drive(1'b0, 32'h3FC00000, 3'b000, 1'b1, 4'd0);
    drive(1'b1, 32'hBFC00000, 3'b000, 1'b1, 4'd0);
    #1;
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL mid_ptr got=%b exp=01", rdy); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_rne();
    test_invalid();
    test_dynamic();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
